// File: rtl/seq_sort6.sv
`default_nettype none
// ============================================================================
// Module   : seq_sort6
// Brief    : Serial N-entry sorter. Loads N values over a valid/ready stream,
//            bubble-sorts in place with one compare-exchange per cycle, and
//            then drains the values in ascending order.
// Revision : 1.0 - initial release
// ============================================================================
module seq_sort6 #(
    parameter int N = 6,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] c_IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] c_J_LAST   = IW'(N - 2);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_buf [N];
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_pass;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic          r_out_last;
    logic          r_busy;

    logic [IW-1:0] w_j1;
    logic [IW-1:0] w_idx_nxt;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_swap;
    logic [W-1:0]  w_first;

    assign w_j1      = r_j + 1'b1;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_a       = r_buf[r_j];
    assign w_b       = r_buf[w_j1];
    assign w_swap    = (w_a > w_b);
    // Value of buf[0] once the current compare lands; the final compare can
    // touch entry 0 only when N == 2.
    assign w_first   = ((r_j == '0) && w_swap) ? w_b : r_buf[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_j         <= '0;
            r_pass      <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_buf[r_idx] <= in_data;
                        if (r_idx == c_IDX_LAST) begin
                            r_idx      <= '0;
                            r_j        <= '0;
                            r_pass     <= '0;
                            r_state    <= S_SORT;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end
                S_SORT: begin
                    if (w_swap) begin
                        r_buf[r_j]  <= w_b;
                        r_buf[w_j1] <= w_a;
                    end
                    if (r_j == c_J_LAST) begin
                        r_j <= '0;
                        if (r_pass == c_J_LAST) begin
                            r_pass      <= '0;
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_first;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                        end
                    end else begin
                        r_j <= w_j1;
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_idx       <= '0;
                            r_state     <= S_LOAD;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_out_data <= r_buf[w_idx_nxt];
                            r_out_last <= (w_idx_nxt == c_IDX_LAST);
                        end
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_sort6.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_sort6
// Brief    : Table-driven bench for seq_sort6 plus a reset-mid-sort sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_sort6;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    seq_sort6 #(.N(6), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][7:0] din;
        logic [5:0][7:0] dexp;
        logic            gaps;
        logic            bp;
        logic            ign;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_batch(input vec_t v, input int id);
        bit         acc;
        int         guard;
        int         cnt;
        int         k;
        int         cyc;
        int         hold_bad;
        int         ign_bad;
        int         stalls;
        bit         hs;
        bit         vld;
        logic [7:0] d;
        logic       l;
        string      tag;
        tag = $sformatf("b%0d", id);
        ign_bad  = 0;
        hold_bad = 0;
        stalls   = 0;
        check({tag, "_in_ready_at_start"}, int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            if (v.gaps) begin
                repeat (i % 3) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = v.din[i];
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) check({tag, "_accept_timeout"}, 0, 1);
        end
        // Now just after the 6th accept edge.
        in_valid = v.ign;
        in_data  = 8'($urandom);
        check({tag, "_busy_in_sort"}, int'(busy), 1);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (in_ready) ign_bad++;
            in_data = 8'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        // out_valid first sampled after edge T+25 lies in cycle T+26.
        check({tag, "_latency"}, cnt + 1, 26);
        k   = 0;
        cyc = 0;
        while (k < 6 && cyc < 200) begin
            out_ready = v.bp ? ((cyc % 3) != 1) : 1'b1;
            hs  = out_valid && out_ready;
            vld = out_valid;
            d   = out_data;
            l   = out_last;
            if (in_ready) ign_bad++;
            in_data = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                check($sformatf("%s_out%0d", tag, k), int'(d), int'(v.dexp[k]));
                check($sformatf("%s_last%0d", tag, k), int'(l), (k == 5) ? 1 : 0);
                k++;
            end else if (vld) begin
                stalls++;
                if (out_data !== d || out_last !== l || out_valid !== 1'b1) hold_bad++;
            end
        end
        if (k < 6) check({tag, "_drain_timeout"}, k, 6);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check({tag, "_ready_after_last"}, int'(in_ready), 1);
        check({tag, "_valid_after_last"}, int'(out_valid), 0);
        if (v.bp) begin
            check({tag, "_hold_stable"}, hold_bad, 0);
            check({tag, "_stalls_seen"}, int'(stalls > 0), 1);
        end
        if (v.ign) check({tag, "_ignored_input"}, ign_bad, 0);
    endtask

    initial begin
        int   cnt;
        vec_t vr;
        tbl[0] = '{din: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},
                   dexp: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                   gaps: 1'b0, bp: 1'b0, ign: 1'b0};
        tbl[1] = '{din: {8'h80, 8'hFF, 8'h00, 8'h7F, 8'h00, 8'hFF},
                   dexp: {8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'h00},
                   gaps: 1'b0, bp: 1'b0, ign: 1'b1};
        tbl[2] = '{din: {8'h01, 8'h55, 8'h03, 8'hAA, 8'h03, 8'h10},
                   dexp: {8'hAA, 8'h55, 8'h10, 8'h03, 8'h03, 8'h01},
                   gaps: 1'b1, bp: 1'b1, ign: 1'b0};
        tbl[3] = '{din: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                   dexp: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                   gaps: 1'b0, bp: 1'b0, ign: 1'b0};
        tbl[4] = '{din: {6{8'd9}},
                   dexp: {6{8'd9}},
                   gaps: 1'b0, bp: 1'b0, ign: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_out_last",  int'(out_last),  0);
        check("rst_busy",      int'(busy),      0);

        // Batches run back to back: each load starts right after the prior drain.
        for (int t = 0; t < 5; t++) begin
            run_batch(tbl[t], t);
        end

        // Reset ten cycles into SORT.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(200 - i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_abort_busy", int'(busy), 1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  int'(in_ready),  1);
        check("abort_busy",      int'(busy),      0);
        check("abort_out_valid", int'(out_valid), 0);
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || busy) cnt++;
        end
        check("abort_no_stale_output", cnt, 0);

        vr = '{din: {8'd4, 8'd5, 8'd6, 8'd2, 8'd1, 8'd3},
               dexp: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               gaps: 1'b0, bp: 1'b0, ign: 1'b0};
        run_batch(vr, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
